// File: rtl/ecc_fault_monitor.sv
// ECC fault monitor: classifies decoder SBE/MBE events, keeps saturating
// counts, an SBE rate window, a first-error log and a NORMAL/DEGRADED/FAULT state.
// Ports: clk, rst (sync, active-high), chk_valid/sbe_flag/mbe_flag/error_pos/
// chk_addr event input, clear_req; state, sbe_count, mbe_count, log_*,
// fault_irq, safe_state_req (all registered).
module ecc_fault_monitor #(
  parameter int ADDR_WIDTH    = 32,
  parameter int SBE_THRESH    = 4,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_valid,
  input  logic                  sbe_flag,
  input  logic                  mbe_flag,
  input  logic [6:0]            error_pos,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic                  clear_req,
  output logic [1:0]            state,
  output logic [15:0]           sbe_count,
  output logic [7:0]            mbe_count,
  output logic                  log_valid,
  output logic                  log_type,
  output logic [6:0]            log_pos,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_overflow,
  output logic                  fault_irq,
  output logic                  safe_state_req
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [7:0]  THRESH   = 8'(SBE_THRESH);

  state_t                state_q, state_d, state_b;
  logic [15:0]           sbe_cnt_q, sbe_cnt_d, sbe_cnt_b;
  logic [7:0]            mbe_cnt_q, mbe_cnt_d, mbe_cnt_b;
  logic [15:0]           win_tmr_q, win_tmr_d;
  logic [7:0]            win_cnt_q, win_cnt_d;
  logic                  lv_q, lv_d, lv_b;
  logic                  lt_q, lt_d, lt_b;
  logic [6:0]            lp_q, lp_d, lp_b;
  logic [ADDR_WIDTH-1:0] la_q, la_d, la_b;
  logic                  ovf_q, ovf_d, ovf_b;
  logic                  irq_q, irq_d;
  logic                  safe_q, safe_d;
  logic                  is_sbe, is_mbe;

  always_comb begin
    is_mbe = chk_valid & mbe_flag;
    is_sbe = chk_valid & sbe_flag & ~mbe_flag;

    // Clear is applied first; the event then acts on the cleared values.
    state_b   = clear_req ? ST_NORMAL : state_q;
    sbe_cnt_b = clear_req ? '0 : sbe_cnt_q;
    mbe_cnt_b = clear_req ? '0 : mbe_cnt_q;
    lv_b      = clear_req ? 1'b0 : lv_q;
    lt_b      = clear_req ? 1'b0 : lt_q;
    lp_b      = clear_req ? '0 : lp_q;
    la_b      = clear_req ? '0 : la_q;
    ovf_b     = clear_req ? 1'b0 : ovf_q;

    // Rate window: a wrap (or clear) restarts the SBE tally,
    // still counting an SBE that lands in that cycle.
    if (clear_req || win_tmr_q == WIN_LAST) begin
      win_tmr_d = '0;
      win_cnt_d = {7'd0, is_sbe};
    end else begin
      win_tmr_d = win_tmr_q + 16'd1;
      win_cnt_d = win_cnt_q;
      if (is_sbe && win_cnt_q != 8'hFF)
        win_cnt_d = win_cnt_q + 8'd1;
    end

    sbe_cnt_d = sbe_cnt_b;
    if (is_sbe && sbe_cnt_b != 16'hFFFF)
      sbe_cnt_d = sbe_cnt_b + 16'd1;

    mbe_cnt_d = mbe_cnt_b;
    if (is_mbe && mbe_cnt_b != 8'hFF)
      mbe_cnt_d = mbe_cnt_b + 8'd1;

    state_d = state_b;
    unique case (state_b)
      ST_NORMAL: begin
        if (is_mbe)
          state_d = ST_FAULT;
        else if (is_sbe && win_cnt_d >= THRESH)
          state_d = ST_DEGRADED;
      end
      ST_DEGRADED: begin
        if (is_mbe)
          state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_NORMAL;
    endcase

    lv_d  = lv_b;
    lt_d  = lt_b;
    lp_d  = lp_b;
    la_d  = la_b;
    ovf_d = ovf_b;
    if (is_sbe || is_mbe) begin
      if (lv_b)
        ovf_d = 1'b1;
      // An MBE outranks a logged SBE; otherwise keep the first error.
      if (!lv_b || (is_mbe && !lt_b)) begin
        lv_d = 1'b1;
        lt_d = is_mbe;
        lp_d = error_pos;
        la_d = chk_addr;
      end
    end

    irq_d  = (state_d != ST_NORMAL);
    safe_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      sbe_cnt_q <= '0;
      mbe_cnt_q <= '0;
      win_tmr_q <= '0;
      win_cnt_q <= '0;
      lv_q      <= 1'b0;
      lt_q      <= 1'b0;
      lp_q      <= '0;
      la_q      <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      safe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sbe_cnt_q <= sbe_cnt_d;
      mbe_cnt_q <= mbe_cnt_d;
      win_tmr_q <= win_tmr_d;
      win_cnt_q <= win_cnt_d;
      lv_q      <= lv_d;
      lt_q      <= lt_d;
      lp_q      <= lp_d;
      la_q      <= la_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      safe_q    <= safe_d;
    end
  end

  assign state          = state_q;
  assign sbe_count      = sbe_cnt_q;
  assign mbe_count      = mbe_cnt_q;
  assign log_valid      = lv_q;
  assign log_type       = lt_q;
  assign log_pos        = lp_q;
  assign log_addr       = la_q;
  assign log_overflow   = ovf_q;
  assign fault_irq      = irq_q;
  assign safe_state_req = safe_q;

endmodule

// File: tb/tb_ecc_fault_monitor.sv
// Testbench for ecc_fault_monitor: scoreboard against a reference model
// plus directed scenario checks.
module tb_ecc_fault_monitor;

  localparam int AW  = 32;
  localparam int THR = 4;
  localparam int WIN = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear_req, chk_valid, sbe_flag, mbe_flag;
  logic [6:0]    error_pos;
  logic [AW-1:0] chk_addr;
  logic [1:0]    state;
  logic [15:0]   sbe_count;
  logic [7:0]    mbe_count;
  logic          log_valid, log_type, log_overflow;
  logic [6:0]    log_pos;
  logic [AW-1:0] log_addr;
  logic          fault_irq, safe_state_req;

  ecc_fault_monitor #(
    .ADDR_WIDTH(AW), .SBE_THRESH(THR), .WINDOW_CYCLES(WIN)
  ) dut (
    .clk(clk), .rst(rst),
    .chk_valid(chk_valid), .sbe_flag(sbe_flag), .mbe_flag(mbe_flag),
    .error_pos(error_pos), .chk_addr(chk_addr), .clear_req(clear_req),
    .state(state), .sbe_count(sbe_count), .mbe_count(mbe_count),
    .log_valid(log_valid), .log_type(log_type), .log_pos(log_pos),
    .log_addr(log_addr), .log_overflow(log_overflow),
    .fault_irq(fault_irq), .safe_state_req(safe_state_req)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic          irq;
    logic          safe;
    logic [15:0]   sc;
    logic [7:0]    mc;
    logic          lv;
    logic          lt;
    logic [6:0]    lp;
    logic [AW-1:0] la;
    logic          ovf;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain integers following the behavioural rules.
  int          m_st, m_sbe, m_mbe, m_win, m_tick;
  int          m_lv, m_lt, m_lp, m_ovf;
  logic [31:0] m_la;

  function automatic void model_reset();
    m_st = 0; m_sbe = 0; m_mbe = 0; m_win = 0; m_tick = 0;
    m_lv = 0; m_lt = 0; m_lp = 0; m_la = '0; m_ovf = 0;
  endfunction

  function automatic void model_step(input logic r, c, v, s, m,
                                     input logic [6:0] p,
                                     input logic [31:0] a);
    bit e_mbe, e_sbe;
    if (r) begin
      model_reset();
      return;
    end
    if (c) begin
      m_st = 0; m_sbe = 0; m_mbe = 0;
      m_lv = 0; m_lt = 0; m_lp = 0; m_la = '0; m_ovf = 0;
    end
    e_mbe = v && m;
    e_sbe = v && s && !m;
    if (c || m_tick == WIN - 1) begin
      m_tick = 0;
      m_win  = e_sbe ? 1 : 0;
    end else begin
      m_tick = m_tick + 1;
      if (e_sbe && m_win < 255) m_win = m_win + 1;
    end
    if (e_sbe && m_sbe < 65535) m_sbe = m_sbe + 1;
    if (e_mbe && m_mbe < 255) m_mbe = m_mbe + 1;
    if (e_mbe) m_st = 2;
    else if (m_st == 0 && e_sbe && m_win >= THR) m_st = 1;
    if (e_mbe || e_sbe) begin
      if (!m_lv || (e_mbe && m_lt == 0)) begin
        if (m_lv) m_ovf = 1;
        m_lv = 1; m_lt = e_mbe ? 1 : 0; m_lp = int'(p); m_la = a;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st   = 2'(m_st);
    o.irq  = (m_st != 0);
    o.safe = (m_st == 2);
    o.sc   = 16'(m_sbe);
    o.mc   = 8'(m_mbe);
    o.lv   = (m_lv != 0);
    o.lt   = (m_lt != 0);
    o.lp   = 7'(m_lp);
    o.la   = m_la;
    o.ovf  = (m_ovf != 0);
    return o;
  endfunction

  // Monitor: one expected entry per clock edge, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{state, fault_irq, safe_state_req, sbe_count, mbe_count,
                log_valid, log_type, log_pos, log_addr, log_overflow};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got st=%0d irq=%0b safe=%0b sc=%0h mc=%0h lv=%0b lt=%0b lp=%0h la=%0h ovf=%0b want st=%0d irq=%0b safe=%0b sc=%0h mc=%0h lv=%0b lt=%0b lp=%0h la=%0h ovf=%0b",
                 $time, mon_a.st, mon_a.irq, mon_a.safe, mon_a.sc, mon_a.mc,
                 mon_a.lv, mon_a.lt, mon_a.lp, mon_a.la, mon_a.ovf,
                 mon_e.st, mon_e.irq, mon_e.safe, mon_e.sc, mon_e.mc,
                 mon_e.lv, mon_e.lt, mon_e.lp, mon_e.la, mon_e.ovf);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, c, v, s, m,
                       input logic [6:0] p, input logic [31:0] a);
    rst = r; clear_req = c; chk_valid = v;
    sbe_flag = s; mbe_flag = m; error_pos = p; chk_addr = a;
    model_step(r, c, v, s, m, p, a);
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic sbe_ev(input logic [6:0] p, input logic [31:0] a);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, p, a);
  endtask

  task automatic mbe_ev(input logic [6:0] p, input logic [31:0] a);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, p, a);
  endtask

  task automatic clr();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  initial begin
    logic r, c, v, s, m;
    int   wait_n;
    rst = 1'b0; clear_req = 1'b0; chk_valid = 1'b0;
    sbe_flag = 1'b0; mbe_flag = 1'b0; error_pos = '0; chk_addr = '0;
    model_reset();

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_sbe", 32'(sbe_count), 32'd0);
    chk("reset_log_valid", 32'(log_valid), 32'd0);
    chk("reset_irq", 32'(fault_irq), 32'd0);

    // Four SBEs ten cycles apart inside one window.
    idle(9); sbe_ev(7'h03, 32'hA0);
    idle(9); sbe_ev(7'h04, 32'hB0);
    idle(9); sbe_ev(7'h05, 32'hC0);
    idle(9);
    chk("pre_thresh_state", 32'(state), 32'd0);
    sbe_ev(7'h06, 32'hD0);
    chk("thresh_state", 32'(state), 32'd1);
    chk("thresh_irq", 32'(fault_irq), 32'd1);
    chk("thresh_sbe", 32'(sbe_count), 32'd4);
    chk("thresh_log_pos", 32'(log_pos), 32'h03);
    chk("thresh_log_addr", log_addr, 32'hA0);
    chk("thresh_ovf", 32'(log_overflow), 32'd1);

    // MBE while DEGRADED.
    mbe_ev(7'h12, 32'h1000);
    chk("mbe_state", 32'(state), 32'd2);
    chk("mbe_safe", 32'(safe_state_req), 32'd1);
    chk("mbe_count", 32'(mbe_count), 32'd1);
    chk("mbe_log_type", 32'(log_type), 32'd1);
    chk("mbe_log_pos", 32'(log_pos), 32'h12);
    chk("mbe_log_addr", log_addr, 32'h1000);

    // Clear coincident with an SBE while in FAULT.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'h05, 32'h2000);
    chk("clr_sbe_state", 32'(state), 32'd0);
    chk("clr_sbe_sbe", 32'(sbe_count), 32'd1);
    chk("clr_sbe_mbe", 32'(mbe_count), 32'd0);
    chk("clr_sbe_lv", 32'(log_valid), 32'd1);
    chk("clr_sbe_lt", 32'(log_type), 32'd0);
    chk("clr_sbe_ovf", 32'(log_overflow), 32'd0);

    // Both flags set is an MBE.
    clr();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'h21, 32'h3000);
    chk("both_mbe", 32'(mbe_count), 32'd1);
    chk("both_sbe", 32'(sbe_count), 32'd0);
    chk("both_state", 32'(state), 32'd2);

    // Three SBEs, window wrap, then one more: no DEGRADED.
    clr();
    sbe_ev(7'h01, 32'h10);
    sbe_ev(7'h02, 32'h20);
    sbe_ev(7'h03, 32'h30);
    idle(1100);
    sbe_ev(7'h04, 32'h40);
    chk("wrap_state", 32'(state), 32'd0);
    chk("wrap_sbe", 32'(sbe_count), 32'd4);

    // MBE counter saturation.
    clr();
    repeat (260) mbe_ev(7'h7F, 32'hFFFF_0000);
    chk("mbe_sat", 32'(mbe_count), 32'hFF);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      c = ($urandom_range(0, 199) == 0);
      v = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 99) == 0);
      drive(r, c, v, s, m, 7'($urandom), $urandom);
    end

    // SBE count saturation, then reset with a coincident SBE.
    clr();
    for (int i = 0; i < 65600; i++)
      sbe_ev(7'(i), 32'(i));
    chk("sbe_sat", 32'(sbe_count), 32'hFFFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'h0A, 32'h5000);
    chk("rst_sbe", 32'(sbe_count), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lv", 32'(log_valid), 32'd0);
    chk("rst_irq", 32'(fault_irq), 32'd0);
    for (int i = 0; i < 200; i++)
      sbe_ev(7'(i), 32'(i + 100));
    chk("post_rst_sbe", 32'(sbe_count), 32'd200);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
